stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle control FSM for a simple in-order core.
// Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB, handles
// HALT/resume, times out stalled memory accesses into FAULT and counts
// retired instructions. Control outputs are combinational from the
// registered state, the latched op class and the current inputs.
module stage_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_mem_ready,
    input  logic        data_ready,
    input  logic [2:0]  op_class,
    input  logic        writes_reg,
    input  logic        branch_taken,
    input  logic        resume,
    output logic        in_mem_en,
    output logic        ir_load,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        data_rd_en,
    output logic        data_wr_en,
    output logic        rf_w_enable,
    output logic        rf_w_select,
    output logic        flags_load,
    output logic [2:0]  state,
    output logic        halted,
    output logic        mem_fault,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5,
        S_FAULT   = 3'd6,
        S_UNUSED  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_HALT   = 3'd4,
        OP_NOP    = 3'd5,
        OP_ILL6   = 3'd6,
        OP_ILL7   = 3'd7
    } op_e;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic        wr_q, wr_d;
    logic [7:0]  wait_q, wait_d;
    logic        mem_fault_q, mem_fault_d;
    logic [31:0] retired_q, retired_d;
    logic        wait_inc;
    logic        timeout_hit;

    // State, op latch, wait counter, fault flag and retirement counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            op_q        <= OP_NOP;
            wr_q        <= 1'b0;
            wait_q      <= '0;
            mem_fault_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wr_q        <= wr_d;
            wait_q      <= wait_d;
            mem_fault_q <= mem_fault_d;
            retired_q   <= retired_d;
        end
    end

    // Next-state decode and control outputs for the current stage
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wr_d        = wr_q;
        mem_fault_d = mem_fault_q;
        wait_inc    = 1'b0;
        timeout_hit = (wait_q == TIMEOUT);
        in_mem_en   = 1'b0;
        ir_load     = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        data_rd_en  = 1'b0;
        data_wr_en  = 1'b0;
        rf_w_enable = 1'b0;
        rf_w_select = 1'b0;
        flags_load  = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_FETCH: begin
                in_mem_en = 1'b1;
                if (in_mem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d     = S_FAULT;
                    mem_fault_d = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                op_d = op_e'(op_class);
                wr_d = writes_reg;
                case (op_e'(op_class))
                    OP_HALT:           state_d = S_HALT;
                    OP_ILL6, OP_ILL7:  state_d = S_FAULT;
                    default:           state_d = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                case (op_q)
                    OP_ALU: begin
                        flags_load = 1'b1;
                        if (wr_q) begin
                            state_d = S_WB;
                        end else begin
                            pc_en   = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    OP_NOP: begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_BRANCH: begin
                        pc_en   = 1'b1;
                        pc_sel  = branch_taken;
                        state_d = S_FETCH;
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (op_q == OP_LOAD || op_q == OP_STORE) begin
                    data_rd_en = (op_q == OP_LOAD);
                    data_wr_en = (op_q == OP_STORE);
                    if (data_ready) begin
                        if (op_q == OP_LOAD) begin
                            state_d = S_WB;
                        end else begin
                            pc_en   = 1'b1;
                            state_d = S_FETCH;
                        end
                    end else if (timeout_hit) begin
                        state_d     = S_FAULT;
                        mem_fault_d = 1'b1;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                rf_w_enable = 1'b1;
                rf_w_select = (op_q == OP_LOAD);
                pc_en       = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // While reset is held no request or strobe may leave the block
        if (!reset) begin
            in_mem_en   = 1'b0;
            ir_load     = 1'b0;
            pc_en       = 1'b0;
            pc_sel      = 1'b0;
            data_rd_en  = 1'b0;
            data_wr_en  = 1'b0;
            rf_w_enable = 1'b0;
            rf_w_select = 1'b0;
            flags_load  = 1'b0;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (wait_inc) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end

        retired_d = pc_en ? (retired_q + 32'd1) : retired_q;
    end

    assign state     = state_q;
    assign mem_fault = mem_fault_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios plus a
// randomized instruction stream whose expected cycle trace is built from
// per-instruction latency rules (fetch waits, memory waits, halt time).
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_mem_ready = 1'b0, data_ready = 1'b0, writes_reg = 1'b0;
    logic        branch_taken = 1'b0, resume = 1'b0;
    logic [2:0]  op_class = 3'd5;
    logic        in_mem_en, ir_load, pc_en, pc_sel, data_rd_en, data_wr_en;
    logic        rf_w_enable, rf_w_select, flags_load, halted, mem_fault;
    logic [2:0]  state;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] C_ALU = 3'd0, C_LOAD = 3'd1, C_STORE = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3, C_HALT = 3'd4, C_NOP = 3'd5;

    // Output vector bit masks: {imen,irl,pcen,pcsel,rd,wr,rfw,rfs,fl,hlt,mf}
    localparam logic [10:0] M_IMEN = 11'h400, M_IRL = 11'h200, M_PCEN = 11'h100;
    localparam logic [10:0] M_PCSEL = 11'h080, M_RD = 11'h040, M_WR = 11'h020;
    localparam logic [10:0] M_RFW = 11'h010, M_RFS = 11'h008, M_FL = 11'h004;
    localparam logic [10:0] M_HLT = 11'h002;

    logic [10:0] obs;
    assign obs = {in_mem_en, ir_load, pc_en, pc_sel, data_rd_en, data_wr_en,
                  rf_w_enable, rf_w_select, flags_load, halted, mem_fault};

    always #5 clk = ~clk;

    stage_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_mem_ready (in_mem_ready),
        .data_ready   (data_ready),
        .op_class     (op_class),
        .writes_reg   (writes_reg),
        .branch_taken (branch_taken),
        .resume       (resume),
        .in_mem_en    (in_mem_en),
        .ir_load      (ir_load),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .data_rd_en   (data_rd_en),
        .data_wr_en   (data_wr_en),
        .rf_w_enable  (rf_w_enable),
        .rf_w_select  (rf_w_select),
        .flags_load   (flags_load),
        .state        (state),
        .halted       (halted),
        .mem_fault    (mem_fault),
        .retired      (retired)
    );

    typedef struct {
        logic [2:0]  st;
        logic [10:0] outs;
        logic        im, dr, res, bt, wr;
        logic [2:0]  opc;
    } cyc_t;

    cyc_t plan[$];

    // Drive one cycle's inputs at the falling edge, then settle
    task automatic step(input logic im, input logic dr, input logic [2:0] opc,
                        input logic wr, input logic bt, input logic res);
        @(negedge clk);
        in_mem_ready = im; data_ready = dr; op_class = opc;
        writes_reg = wr; branch_taken = bt; resume = res;
        #1;
    endtask

    // Pulse reset; the next falling edge lands in the first FETCH cycle
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_mem_ready = 1'b0; data_ready = 1'b0; resume = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    function automatic cyc_t rc(input logic [2:0] st, input logic [10:0] o);
        cyc_t c;
        c.st = st; c.outs = o;
        c.im = 1'($urandom); c.dr = 1'($urandom); c.res = 1'($urandom);
        c.bt = 1'($urandom); c.wr = 1'($urandom); c.opc = 3'($urandom);
        return c;
    endfunction

    // Expected cycle trace of one instruction from the stage latency rules
    function automatic void plan_instr(input logic [2:0] op, input logic wr, input logic bt,
                                       input int fw, input int mw, input int hw);
        cyc_t c;
        logic [10:0] req;
        for (int i = 0; i < fw; i++) begin
            c = rc(3'd0, M_IMEN); c.im = 1'b0; plan.push_back(c);
        end
        c = rc(3'd0, M_IMEN | M_IRL); c.im = 1'b1; plan.push_back(c);
        c = rc(3'd1, '0); c.opc = op; c.wr = wr; plan.push_back(c);
        if (op == C_HALT) begin
            for (int i = 0; i < hw; i++) begin
                c = rc(3'd5, M_HLT); c.res = 1'b0; plan.push_back(c);
            end
            c = rc(3'd5, M_HLT | M_PCEN); c.res = 1'b1; plan.push_back(c);
            return;
        end
        case (op)
            C_ALU:    c = rc(3'd2, M_FL | (wr ? 11'h0 : M_PCEN));
            C_NOP:    c = rc(3'd2, M_PCEN);
            C_BRANCH: c = rc(3'd2, M_PCEN | (bt ? M_PCSEL : 11'h0));
            default:  c = rc(3'd2, '0);
        endcase
        c.bt = bt; plan.push_back(c);
        if (op == C_LOAD || op == C_STORE) begin
            req = (op == C_LOAD) ? M_RD : M_WR;
            for (int i = 0; i < mw; i++) begin
                c = rc(3'd3, req); c.dr = 1'b0; plan.push_back(c);
            end
            c = rc(3'd3, req | ((op == C_STORE) ? M_PCEN : 11'h0)); c.dr = 1'b1;
            plan.push_back(c);
        end
        if ((op == C_ALU && wr) || op == C_LOAD) begin
            c = rc(3'd4, M_RFW | M_PCEN | ((op == C_LOAD) ? M_RFS : 11'h0));
            plan.push_back(c);
        end
    endfunction

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; in_mem_ready = 1'b1;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got=%0h exp=0", retired); end
        checks++; if ({halted, mem_fault} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {halted, mem_fault}); end
        checks++; if ({in_mem_en, ir_load} !== 2'b00) begin errors++; $display("FAIL reset_no_req got=%b exp=00", {in_mem_en, ir_load}); end
        in_mem_ready = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk); #1;
        checks++; if ({state, in_mem_en} !== {3'd0, 1'b1}) begin errors++; $display("FAIL first_fetch got=%0d/%b exp=0/1", state, in_mem_en); end
    endtask

    task automatic test_alu_write();
        do_reset();
        step(1, 0, C_NOP, 0, 0, 0);
        checks++; if ({state, ir_load} !== {3'd0, 1'b1}) begin errors++; $display("FAIL alu_fetch got=%0d/%b exp=0/1", state, ir_load); end
        step(0, 0, C_ALU, 1, 0, 0);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL alu_decode got=%0d exp=1", state); end
        step(1, 1, 3'd7, 0, 1, 1);
        checks++; if ({state, flags_load, pc_en} !== {3'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL alu_exec got=%0d/%b%b exp=2/10", state, flags_load, pc_en); end
        step(1, 1, 3'd7, 0, 1, 1);
        checks++; if ({state, rf_w_enable, rf_w_select, pc_en} !== {3'd4, 3'b101}) begin errors++; $display("FAIL alu_wb got=%0d/%b%b%b exp=4/101", state, rf_w_enable, rf_w_select, pc_en); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL alu_retired_before got=%0d exp=0", retired); end
        step(0, 0, C_NOP, 0, 0, 0);
        checks++; if ({state, retired} !== {3'd0, 32'd1}) begin errors++; $display("FAIL alu_done got=%0d/%0d exp=0/1", state, retired); end
    endtask

    task automatic test_load_delay();
        int mem_cycles = 0;
        do_reset();
        step(1, 0, C_NOP, 0, 0, 0);
        step(0, 0, C_LOAD, 0, 0, 0);
        step(0, 0, C_NOP, 0, 0, 0);
        checks++; if ({state, data_rd_en} !== {3'd2, 1'b0}) begin errors++; $display("FAIL load_exec got=%0d/%b exp=2/0", state, data_rd_en); end
        for (int i = 0; i < 4; i++) begin
            step(0, (i == 3), C_NOP, 0, 0, 0);
            if (state == 3'd3 && data_rd_en && !data_wr_en) mem_cycles++;
        end
        checks++; if (mem_cycles !== 4) begin errors++; $display("FAIL load_mem_cycles got=%0d exp=4", mem_cycles); end
        step(0, 0, C_NOP, 0, 0, 0);
        checks++; if ({state, rf_w_enable, rf_w_select, pc_en} !== {3'd4, 3'b111}) begin errors++; $display("FAIL load_wb got=%0d/%b%b%b exp=4/111", state, rf_w_enable, rf_w_select, pc_en); end
        step(0, 0, C_NOP, 0, 0, 0);
        checks++; if ({state, retired} !== {3'd0, 32'd1}) begin errors++; $display("FAIL load_done got=%0d/%0d exp=0/1", state, retired); end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 2; t++) begin
            do_reset();
            step(1, 0, C_NOP, 0, 0, 0);
            step(0, 0, C_BRANCH, 0, 0, 0);
            step(0, 0, C_NOP, 0, 1'(t), 0);
            checks++; if ({state, pc_en, pc_sel} !== {3'd2, 1'b1, 1'(t)}) begin errors++; $display("FAIL branch_exec_t%0d got=%0d/%b%b exp=2/1%0d", t, state, pc_en, pc_sel, t); end
            step(0, 0, C_NOP, 0, 0, 0);
            checks++; if ({state, retired} !== {3'd0, 32'd1}) begin errors++; $display("FAIL branch_done_t%0d got=%0d/%0d exp=0/1", t, state, retired); end
        end
    endtask

    task automatic test_ready_wins();
        do_reset();
        for (int i = 0; i < 15; i++) step(0, 0, C_NOP, 0, 0, 0);
        step(1, 0, C_NOP, 0, 0, 0);
        checks++; if ({state, ir_load} !== {3'd0, 1'b1}) begin errors++; $display("FAIL ready_wins_fetch got=%0d/%b exp=0/1", state, ir_load); end
        step(0, 0, C_NOP, 0, 0, 0);
        checks++; if ({state, mem_fault} !== {3'd1, 1'b0}) begin errors++; $display("FAIL ready_wins_decode got=%0d/%b exp=1/0", state, mem_fault); end
    endtask

    task automatic test_fetch_timeout();
        int n = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(0, 0, C_NOP, 0, 0, 0);
            if (state == 3'd6) break;
            n++;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL fetch_timeout_cycles got=%0d exp=16", n); end
        checks++; if ({halted, mem_fault, in_mem_en} !== 3'b110) begin errors++; $display("FAIL fetch_fault_flags got=%b exp=110", {halted, mem_fault, in_mem_en}); end
        for (int i = 0; i < 3; i++) step(1, 1, C_NOP, 0, 0, 1);
        checks++; if ({state, pc_en, retired} !== {3'd6, 1'b0, 32'd0}) begin errors++; $display("FAIL fault_resume_ignored got=%0d/%b/%0d exp=6/0/0", state, pc_en, retired); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if ({state, halted, mem_fault} !== {3'd0, 2'b00}) begin errors++; $display("FAIL fault_reset got=%0d/%b%b exp=0/00", state, halted, mem_fault); end
    endtask

    task automatic test_mem_timeout();
        int n = 0;
        do_reset();
        step(1, 0, C_NOP, 0, 0, 0);
        step(0, 0, C_STORE, 0, 0, 0);
        step(0, 0, C_NOP, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 0, C_NOP, 0, 0, 0);
            if (state != 3'd3 || !data_wr_en) break;
            n++;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL mem_timeout_cycles got=%0d exp=16", n); end
        checks++; if ({state, mem_fault, data_wr_en, retired} !== {3'd6, 2'b10, 32'd0}) begin errors++; $display("FAIL mem_fault got=%0d/%b%b/%0d exp=6/10/0", state, mem_fault, data_wr_en, retired); end
    endtask

    task automatic test_illegal();
        do_reset();
        step(1, 0, C_NOP, 0, 0, 0);
        step(0, 0, 3'd6, 0, 0, 0);
        step(1, 1, C_NOP, 0, 0, 1);
        checks++; if ({state, halted, mem_fault} !== {3'd6, 2'b10}) begin errors++; $display("FAIL illegal_fault got=%0d/%b%b exp=6/10", state, halted, mem_fault); end
    endtask

    task automatic test_halt_resume();
        int hcount = 0;
        do_reset();
        step(1, 0, C_NOP, 0, 0, 0);
        step(0, 0, C_HALT, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 1, C_NOP, 0, 0, 0);
            if (state == 3'd5 && halted && !pc_en && !in_mem_en && retired == 0) hcount++;
        end
        step(1, 1, C_NOP, 0, 0, 1);
        if (halted) hcount++;
        checks++; if (hcount !== 10) begin errors++; $display("FAIL halt_cycles got=%0d exp=10", hcount); end
        checks++; if ({state, pc_en, pc_sel} !== {3'd5, 2'b10}) begin errors++; $display("FAIL halt_resume got=%0d/%b%b exp=5/10", state, pc_en, pc_sel); end
        step(0, 0, C_NOP, 0, 0, 0);
        checks++; if ({state, halted, retired} !== {3'd0, 1'b0, 32'd1}) begin errors++; $display("FAIL halt_exit got=%0d/%b/%0d exp=0/0/1", state, halted, retired); end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.retired_q = 32'hFFFF_FFFF;
        step(1, 0, C_NOP, 0, 0, 0);
        step(0, 0, C_NOP, 0, 0, 0);
        release dut.retired_q;
        step(0, 0, C_NOP, 0, 0, 0);
        checks++; if ({pc_en, retired} !== {1'b1, 32'hFFFF_FFFF}) begin errors++; $display("FAIL wrap_before got=%b/%0h exp=1/ffffffff", pc_en, retired); end
        step(0, 0, C_NOP, 0, 0, 0);
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL wrap_after got=%0h exp=0", retired); end
    endtask

    task automatic test_reset_in_mem();
        do_reset();
        step(1, 0, C_NOP, 0, 0, 0);
        step(0, 0, C_LOAD, 0, 0, 0);
        step(0, 0, C_NOP, 0, 0, 0);
        step(0, 0, C_NOP, 0, 0, 0);
        checks++; if ({state, data_rd_en} !== {3'd3, 1'b1}) begin errors++; $display("FAIL rstmem_pre got=%0d/%b exp=3/1", state, data_rd_en); end
        #2 reset = 1'b0; #1;
        checks++; if ({state, data_rd_en} !== {3'd0, 1'b0}) begin errors++; $display("FAIL rstmem_async got=%0d/%b exp=0/0", state, data_rd_en); end
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk); #1;
        checks++; if ({state, data_rd_en, data_wr_en, in_mem_en, retired} !== {3'd0, 3'b001, 32'd0}) begin errors++; $display("FAIL rstmem_after got=%0d/%b%b%b/%0d exp=0/001/0", state, data_rd_en, data_wr_en, in_mem_en, retired); end
    endtask

    task automatic test_random_program();
        int unsigned model_retired = 0;
        logic [2:0] op;
        cyc_t c;
        int fw, mw;
        plan.delete();
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 5));
            fw = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 4));
            mw = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 4));
            plan_instr(op, 1'($urandom), 1'($urandom), fw, mw, int'($urandom_range(0, 5)));
        end
        do_reset();
        for (int k = 0; k < plan.size(); k++) begin
            c = plan[k];
            step(c.im, c.dr, c.opc, c.wr, c.bt, c.res);
            checks++; if (state !== c.st) begin errors++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", k, state, c.st); end
            checks++; if (obs !== c.outs) begin errors++; $display("FAIL rnd_outs cyc=%0d got=%b exp=%b", k, obs, c.outs); end
            checks++; if (retired !== model_retired) begin errors++; $display("FAIL rnd_retired cyc=%0d got=%0d exp=%0d", k, retired, model_retired); end
            if ((c.outs & M_PCEN) != 0) model_retired++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_write();
        test_load_delay();
        test_branch();
        test_ready_wins();
        test_fetch_timeout();
        test_mem_timeout();
        test_illegal();
        test_halt_resume();
        test_wrap();
        test_reset_in_mem();
        test_random_program();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
